// File: rtl/alu_exec_seq.sv
// Execute-stage ALU: decodes aluOP/functField and runs single-cycle logic/arithmetic ops,
// plus iterative multu/divu (one shift step per cycle) that write the HI/LO pair.
module alu_exec_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       aluOP,
    input  logic [5:0]       functField,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic [3:0]       aluCtrl,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             illegal
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;

    localparam logic [3:0] CTRL_AND   = 4'b0000;
    localparam logic [3:0] CTRL_OR    = 4'b0001;
    localparam logic [3:0] CTRL_ADD   = 4'b0010;
    localparam logic [3:0] CTRL_SUB   = 4'b0110;
    localparam logic [3:0] CTRL_SLT   = 4'b0111;
    localparam logic [3:0] CTRL_MULTU = 4'b1000;
    localparam logic [3:0] CTRL_DIVU  = 4'b1001;
    localparam logic [3:0] CTRL_MFHI  = 4'b1010;
    localparam logic [3:0] CTRL_MFLO  = 4'b1011;
    localparam logic [3:0] CTRL_NOR   = 4'b1100;
    localparam logic [3:0] CTRL_ILL   = 4'b1111;

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] accHi;   // partial product high half / running remainder
    logic [WIDTH-1:0] accLo;   // multiplier bits / dividend bits turning into quotient
    logic [WIDTH-1:0] opB;     // captured multiplicand or divisor

    logic [3:0]       decodedCtrl;
    logic [WIDTH-1:0] aluResult;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        decodedCtrl = CTRL_ILL;
        case (aluOP)
            2'b00:   decodedCtrl = CTRL_ADD;
            2'b01:   decodedCtrl = CTRL_SUB;
            default: begin
                case (functField)
                    6'b100000: decodedCtrl = CTRL_ADD;
                    6'b100010: decodedCtrl = CTRL_SUB;
                    6'b100100: decodedCtrl = CTRL_AND;
                    6'b100101: decodedCtrl = CTRL_OR;
                    6'b100111: decodedCtrl = CTRL_NOR;
                    6'b101010: decodedCtrl = CTRL_SLT;
                    6'b010000: decodedCtrl = CTRL_MFHI;
                    6'b010010: decodedCtrl = CTRL_MFLO;
                    6'b011001: decodedCtrl = CTRL_MULTU;
                    6'b011011: decodedCtrl = CTRL_DIVU;
                    default:   decodedCtrl = CTRL_ILL;
                endcase
            end
        endcase
    end

    always_comb begin
        aluResult = '0;
        case (decodedCtrl)
            CTRL_ADD:  aluResult = srcA + srcB;
            CTRL_SUB:  aluResult = srcA - srcB;
            CTRL_AND:  aluResult = srcA & srcB;
            CTRL_OR:   aluResult = srcA | srcB;
            CTRL_NOR:  aluResult = ~(srcA | srcB);
            CTRL_SLT:  aluResult = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
            CTRL_MFHI: aluResult = hi;
            CTRL_MFLO: aluResult = lo;
            default:   aluResult = '0;
        endcase
    end

    // Shift-add multiply step: conditionally add multiplicand, then shift {accHi,accLo} right.
    logic [WIDTH:0]   mulSum;
    logic [WIDTH-1:0] mulHiNext;
    logic [WIDTH-1:0] mulLoNext;

    assign mulSum    = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : '0);
    assign mulHiNext = mulSum[WIDTH:1];
    assign mulLoNext = {mulSum[0], accLo[WIDTH-1:1]};

    // Restoring divide step: borrow in the top bit of divDiff means the trial subtract failed.
    logic [WIDTH:0]   divShift;
    logic [WIDTH:0]   divDiff;
    logic             divFits;
    logic [WIDTH-1:0] divHiNext;
    logic [WIDTH-1:0] divLoNext;

    assign divShift  = {accHi, accLo[WIDTH-1]};
    assign divDiff   = divShift - {1'b0, opB};
    assign divFits   = ~divDiff[WIDTH];
    assign divHiNext = divFits ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
    assign divLoNext = {accLo[WIDTH-2:0], divFits};

    logic [WIDTH-1:0] stepHi;
    logic [WIDTH-1:0] stepLo;
    logic             lastStep;

    assign stepHi   = (state == MUL) ? mulHiNext : divHiNext;
    assign stepLo   = (state == MUL) ? mulLoNext : divLoNext;
    assign lastStep = (count == CNT_W'(WIDTH - 1));

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            accHi   <= '0;
            accLo   <= '0;
            opB     <= '0;
            aluCtrl <= '0;
            result  <= '0;
            zero    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        aluCtrl <= decodedCtrl;
                        if (decodedCtrl == CTRL_MULTU || decodedCtrl == CTRL_DIVU) begin
                            accHi <= '0;
                            accLo <= (decodedCtrl == CTRL_MULTU) ? srcB : srcA;
                            opB   <= (decodedCtrl == CTRL_MULTU) ? srcA : srcB;
                            count <= '0;
                            busy  <= 1'b1;
                            state <= (decodedCtrl == CTRL_MULTU) ? MUL : DIV;
                        end else begin
                            result  <= aluResult;
                            zero    <= (aluResult == '0);
                            done    <= 1'b1;
                            illegal <= (decodedCtrl == CTRL_ILL);
                        end
                    end
                end
                MUL, DIV: begin
                    accHi <= stepHi;
                    accLo <= stepLo;
                    count <= count + 1'b1;
                    if (lastStep) begin
                        hi     <= stepHi;
                        lo     <= stepLo;
                        result <= stepLo;
                        zero   <= (stepLo == '0);
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench for alu_exec_seq at WIDTH=32 and WIDTH=8 with hand-computed expectations.
module tb_alu_exec_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    logic        start32 = 1'b0;
    logic [1:0]  aluOP32 = '0;
    logic [5:0]  funct32 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [3:0]  aluCtrl32;
    logic [31:0] result32, hi32, lo32;
    logic        zero32, busy32, done32, illegal32;

    logic        start8 = 1'b0;
    logic [1:0]  aluOP8 = '0;
    logic [5:0]  funct8 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [3:0]  aluCtrl8;
    logic [7:0]  result8, hi8, lo8;
    logic        zero8, busy8, done8, illegal8;

    alu_exec_seq #(.WIDTH(32), .CNT_W(6)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .aluOP(aluOP32), .functField(funct32),
        .srcA(a32), .srcB(b32), .aluCtrl(aluCtrl32), .result(result32), .zero(zero32),
        .hi(hi32), .lo(lo32), .busy(busy32), .done(done32), .illegal(illegal32)
    );

    alu_exec_seq #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .aluOP(aluOP8), .functField(funct8),
        .srcA(a8), .srcB(b8), .aluCtrl(aluCtrl8), .result(result8), .zero(zero8),
        .hi(hi8), .lo(lo8), .busy(busy8), .done(done8), .illegal(illegal8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue32(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        aluOP32 = op; funct32 = fn; a32 = a; b32 = b; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
    endtask

    task automatic issue8(input logic [1:0] op, input logic [5:0] fn, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        aluOP8 = op; funct8 = fn; a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    // Counts edges until done; optionally pokes a start and new operands while busy.
    task automatic wait32(input bit poke, output int cyc, output bit busyBad);
        cyc = 0;
        busyBad = 1'b0;
        while (!done32 && cyc < 40) begin
            if (busy32 !== 1'b1) busyBad = 1'b1;
            @(posedge clk); #1;
            cyc++;
            if (poke && cyc == 10) begin
                start32 = 1'b1; aluOP32 = 2'b10; funct32 = 6'b100000; a32 = 32'h1; b32 = 32'h1;
            end else begin
                start32 = 1'b0;
            end
        end
        if (done32 && busy32 !== 1'b0) busyBad = 1'b1;
    endtask

    task automatic wait8(output int cyc);
        cyc = 0;
        while (!done8 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    // Independent 8-bit reference: returns {illegal, result}.
    function automatic logic [8:0] model8(input logic [1:0] op, input logic [5:0] fn,
                                          input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] h, input logic [7:0] l);
        if (op == 2'b00) return {1'b0, 8'(a + b)};
        if (op == 2'b01) return {1'b0, 8'(a - b)};
        case (fn)
            6'b100000: return {1'b0, 8'(a + b)};
            6'b100010: return {1'b0, 8'(a - b)};
            6'b100100: return {1'b0, a & b};
            6'b100101: return {1'b0, a | b};
            6'b100111: return {1'b0, ~(a | b)};
            6'b101010: return {1'b0, 7'd0, ($signed(a) < $signed(b))};
            6'b010000: return {1'b0, h};
            6'b010010: return {1'b0, l};
            default:   return {1'b1, 8'h00};
        endcase
    endfunction

    logic [5:0] fnTable [9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111,
                                6'b101010, 6'b010000, 6'b010010, 6'b000001};

    initial begin
        int cyc;
        bit busyBad;
        bit sawDone;
        logic [1:0] op;
        logic [5:0] fn;
        logic [7:0] ra, rb;
        logic [8:0] exp8;

        #2;
        check("reset ctrl/flags", {aluCtrl32, busy32, done32, illegal32, zero32}, 0);
        check("reset result/hi/lo", {result32 | hi32 | lo32}, 0);
        @(negedge clk); rst_n = 1'b1;

        issue32(2'b10, 6'b100000, 32'd7, 32'd5);
        check("add result", result32, 32'd12);
        check("add done/ctrl", {done32, busy32, aluCtrl32, zero32}, {1'b1, 1'b0, 4'b0010, 1'b0});
        @(posedge clk); #1;
        check("done pulse ends", done32, 1'b0);

        issue32(2'b10, 6'b100010, 32'd5, 32'd5);
        check("sub zero", {result32, zero32, aluCtrl32}, {32'd0, 1'b1, 4'b0110});
        issue32(2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1);
        check("slt signed", {result32, aluCtrl32}, {32'd1, 4'b0111});
        issue32(2'b10, 6'b101010, 32'd1, 32'hFFFFFFFF);
        check("slt false", {result32, zero32}, {32'd0, 1'b1});
        issue32(2'b10, 6'b100111, 32'd0, 32'd0);
        check("nor", {result32, aluCtrl32}, {32'hFFFFFFFF, 4'b1100});
        issue32(2'b10, 6'b100100, 32'h0000F0F0, 32'h0000FF00);
        check("and", result32, 32'h0000F000);
        issue32(2'b10, 6'b100101, 32'h0000F0F0, 32'h00000F0F);
        check("or", result32, 32'h0000FFFF);
        issue32(2'b00, 6'b101010, 32'd3, 32'd4);
        check("aluOP00 add", {result32, aluCtrl32}, {32'd7, 4'b0010});
        issue32(2'b01, 6'b100000, 32'd3, 32'd4);
        check("aluOP01 sub", {result32, aluCtrl32}, {32'hFFFFFFFF, 4'b0110});

        issue32(2'b10, 6'b011001, 32'hFFFFFFFF, 32'd2);
        check("multu accept", {busy32, done32, aluCtrl32}, {1'b1, 1'b0, 4'b1000});
        a32 = 32'h12345678;
        wait32(1'b1, cyc, busyBad);
        check("multu latency", cyc, 32);
        check("multu busy", busyBad, 1'b0);
        check("multu hi/lo", {hi32, lo32}, {32'h00000001, 32'hFFFFFFFE});
        check("multu result/ctrl", {result32, aluCtrl32}, {32'hFFFFFFFE, 4'b1000});
        issue32(2'b10, 6'b010000, 32'd0, 32'd0);
        check("mfhi after multu", {result32, aluCtrl32, done32}, {32'h00000001, 4'b1010, 1'b1});
        issue32(2'b10, 6'b010010, 32'd0, 32'd0);
        check("mflo", result32, 32'hFFFFFFFE);

        issue32(2'b10, 6'b011011, 32'd100, 32'd7);
        wait32(1'b0, cyc, busyBad);
        check("divu latency", cyc, 32);
        check("divu 100/7", {hi32, lo32, result32}, {32'd2, 32'd14, 32'd14});
        issue32(2'b10, 6'b011011, 32'd9, 32'd0);
        wait32(1'b0, cyc, busyBad);
        check("divu by zero", {hi32, lo32, aluCtrl32}, {32'd9, 32'hFFFFFFFF, 4'b1001});

        issue32(2'b10, 6'b111111, 32'd3, 32'd4);
        check("illegal pulse", {aluCtrl32, done32, illegal32, zero32, busy32}, {4'b1111, 1'b1, 1'b1, 1'b1, 1'b0});
        check("illegal result/hilo", {result32, hi32, lo32}, {32'd0, 32'd9, 32'hFFFFFFFF});
        @(posedge clk); #1;
        check("illegal ends", {done32, illegal32}, 2'b00);

        issue32(2'b10, 6'b011001, 32'd3, 32'd5);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset flags", {aluCtrl32, busy32, done32, illegal32, zero32}, 0);
        check("async reset data", {result32 | hi32 | lo32}, 0);
        @(negedge clk); rst_n = 1'b1;
        sawDone = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done32 || busy32) sawDone = 1'b1;
        end
        check("post-reset idle", {sawDone, hi32, lo32}, 0);

        issue8(2'b10, 6'b011001, 8'hFF, 8'hFF);
        wait8(cyc);
        check("w8 multu latency", cyc, 8);
        check("w8 multu hi/lo", {hi8, lo8}, {8'hFE, 8'h01});

        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            fn = fnTable[$urandom_range(0, 8)];
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            exp8 = model8(op, fn, ra, rb, 8'hFE, 8'h01);
            issue8(op, fn, ra, rb);
            check($sformatf("w8 op%0d fn%b", op, fn), {illegal8, result8, zero8, done8},
                  {exp8, (exp8[7:0] == 8'h00), 1'b1});
        end
        check("w8 hi/lo held", {hi8, lo8}, {8'hFE, 8'h01});

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
